// File: rtl/phaser_tap_ctrl.sv
// Per-lane fine/coarse delay tap controller with settle handshake,
// counter readback and divider-resync serializer reset pulses.
module phaser_tap_ctrl #(
  parameter int LANES          = 4,
  parameter int FINE_W         = 6,
  parameter int COARSE_W       = 3,
  parameter int COARSE_MAX     = 7,
  parameter int SETTLE         = 2,
  parameter int EN_OSERDES_RST = 1,
  parameter int RST_PULSE      = 4,
  localparam int LSW = (LANES > 1) ? $clog2(LANES) : 1,
  localparam int TW  = FINE_W + COARSE_W
) (
  input  logic                         SYSCLK,
  input  logic                         RST,
  input  logic [LSW-1:0]               LANESEL,
  input  logic                         FINEENABLE,
  input  logic                         FINEINC,
  input  logic                         COARSEENABLE,
  input  logic                         COARSEINC,
  input  logic                         COUNTERLOADEN,
  input  logic [TW-1:0]                COUNTERLOADVAL,
  input  logic                         COUNTERREADEN,
  output logic [TW-1:0]                COUNTERREADVAL,
  input  logic                         DIVIDERST,
  output logic                         READVALID,
  output logic                         BUSY,
  output logic [LANES-1:0]             FINEOVERFLOW,
  output logic [LANES-1:0]             COARSEOVERFLOW,
  output logic [LANES-1:0]             OSERDESRST,
  output logic [LANES*FINE_W-1:0]      FINETAP,
  output logic [LANES*COARSE_W-1:0]    COARSETAP
);

  typedef enum logic {
    S_IDLE,
    S_SETTLE
  } state_t;

  localparam logic [COARSE_W-1:0] CMAX = COARSE_W'(COARSE_MAX);

  state_t              state;
  logic [3:0]          settle_cnt;
  logic [FINE_W-1:0]   fine_q   [LANES];
  logic [COARSE_W-1:0] coarse_q [LANES];
  logic                lane_ok;
  logic                any_req;
  logic [COARSE_W-1:0] ld_coarse_raw;
  logic [COARSE_W-1:0] ld_coarse;
  logic [FINE_W-1:0]   ld_fine;

  assign lane_ok       = ({1'b0, LANESEL} < (LSW+1)'(LANES));
  assign any_req       = COUNTERLOADEN | COARSEENABLE | FINEENABLE;
  assign ld_coarse_raw = COUNTERLOADVAL[TW-1:FINE_W];
  assign ld_fine       = COUNTERLOADVAL[FINE_W-1:0];
  assign ld_coarse     = (ld_coarse_raw > CMAX) ? CMAX : ld_coarse_raw;

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state          <= S_IDLE;
      BUSY           <= 1'b0;
      settle_cnt     <= '0;
      FINEOVERFLOW   <= '0;
      COARSEOVERFLOW <= '0;
      for (int i = 0; i < LANES; i++) begin
        fine_q[i]   <= '0;
        coarse_q[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (lane_ok && any_req) begin
            state      <= S_SETTLE;
            BUSY       <= 1'b1;
            settle_cnt <= 4'(SETTLE - 1);
            if (COUNTERLOADEN) begin
              fine_q[LANESEL]         <= ld_fine;
              coarse_q[LANESEL]       <= ld_coarse;
              FINEOVERFLOW[LANESEL]   <= 1'b0;
              COARSEOVERFLOW[LANESEL] <= 1'b0;
            end else if (COARSEENABLE) begin
              // coarse saturates at both ends, flagging the attempt
              if (COARSEINC) begin
                if (coarse_q[LANESEL] >= CMAX)
                  COARSEOVERFLOW[LANESEL] <= 1'b1;
                else
                  coarse_q[LANESEL] <= coarse_q[LANESEL] + 1'b1;
              end else begin
                if (coarse_q[LANESEL] == '0)
                  COARSEOVERFLOW[LANESEL] <= 1'b1;
                else
                  coarse_q[LANESEL] <= coarse_q[LANESEL] - 1'b1;
              end
            end else begin
              // fine wraps modulo 2^FINE_W
              if (FINEINC) begin
                fine_q[LANESEL] <= fine_q[LANESEL] + 1'b1;
                if (&fine_q[LANESEL])
                  FINEOVERFLOW[LANESEL] <= 1'b1;
              end else begin
                fine_q[LANESEL] <= fine_q[LANESEL] - 1'b1;
                if (fine_q[LANESEL] == '0)
                  FINEOVERFLOW[LANESEL] <= 1'b1;
              end
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // readback samples the pre-update taps of the selected lane
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      READVALID      <= 1'b0;
      COUNTERREADVAL <= '0;
    end else begin
      READVALID <= COUNTERREADEN;
      if (COUNTERREADEN) begin
        if (lane_ok)
          COUNTERREADVAL <= {coarse_q[LANESEL], fine_q[LANESEL]};
        else
          COUNTERREADVAL <= '0;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_tap
    assign FINETAP[g*FINE_W +: FINE_W]       = fine_q[g];
    assign COARSETAP[g*COARSE_W +: COARSE_W] = coarse_q[g];
  end

  if (EN_OSERDES_RST != 0) begin : g_os
    logic [3:0] rem;
    logic       os_q;

    // rem counts further high cycles still owed after the current one
    always_ff @(posedge SYSCLK or posedge RST) begin
      if (RST) begin
        os_q <= 1'b1;
        rem  <= 4'(RST_PULSE);
      end else if (DIVIDERST) begin
        os_q <= 1'b1;
        rem  <= 4'(RST_PULSE - 1);
      end else if (rem != '0) begin
        os_q <= 1'b1;
        rem  <= rem - 1'b1;
      end else begin
        os_q <= 1'b0;
      end
    end

    assign OSERDESRST = {LANES{os_q}};
  end else begin : g_no_os
    assign OSERDESRST = '0;
  end

endmodule

// File: tb/tb_phaser_tap_ctrl.sv
// Scoreboard bench for phaser_tap_ctrl: directed tap steps, loads,
// readback queue, resync pulses and reset abort.
module tb_phaser_tap_ctrl;

  localparam int LANES = 4;
  localparam int FW    = 6;
  localparam int CW    = 3;
  localparam int TW    = FW + CW;

  logic               SYSCLK = 1'b0;
  logic               RST = 1'b1;
  logic [1:0]         LANESEL = '0;
  logic               FINEENABLE = 1'b0;
  logic               FINEINC = 1'b0;
  logic               COARSEENABLE = 1'b0;
  logic               COARSEINC = 1'b0;
  logic               COUNTERLOADEN = 1'b0;
  logic [TW-1:0]      COUNTERLOADVAL = '0;
  logic               COUNTERREADEN = 1'b0;
  logic [TW-1:0]      COUNTERREADVAL;
  logic               DIVIDERST = 1'b0;
  logic               READVALID;
  logic               BUSY;
  logic [LANES-1:0]   FINEOVERFLOW;
  logic [LANES-1:0]   COARSEOVERFLOW;
  logic [LANES-1:0]   OSERDESRST;
  logic [LANES*FW-1:0] FINETAP;
  logic [LANES*CW-1:0] COARSETAP;

  int total = 0;
  int bad = 0;
  logic [TW-1:0] rdq[$];

  always #5 SYSCLK = ~SYSCLK;

  phaser_tap_ctrl dut (
    .SYSCLK(SYSCLK), .RST(RST), .LANESEL(LANESEL),
    .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
    .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
    .COUNTERLOADEN(COUNTERLOADEN), .COUNTERLOADVAL(COUNTERLOADVAL),
    .COUNTERREADEN(COUNTERREADEN), .COUNTERREADVAL(COUNTERREADVAL),
    .DIVIDERST(DIVIDERST), .READVALID(READVALID), .BUSY(BUSY),
    .FINEOVERFLOW(FINEOVERFLOW), .COARSEOVERFLOW(COARSEOVERFLOW),
    .OSERDESRST(OSERDESRST), .FINETAP(FINETAP), .COARSETAP(COARSETAP)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] ftap(int l);
    return FINETAP[l*FW +: FW];
  endfunction

  function automatic logic [CW-1:0] ctap(int l);
    return COARSETAP[l*CW +: CW];
  endfunction

  task automatic cyc();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic settle();
    cyc();
    cyc();
  endtask

  task automatic fine(int l, bit inc);
    LANESEL = 2'(l);
    FINEENABLE = 1'b1;
    FINEINC = inc;
    cyc();
    FINEENABLE = 1'b0;
  endtask

  task automatic coarse(int l, bit inc);
    LANESEL = 2'(l);
    COARSEENABLE = 1'b1;
    COARSEINC = inc;
    cyc();
    COARSEENABLE = 1'b0;
  endtask

  task automatic load(int l, logic [TW-1:0] v);
    LANESEL = 2'(l);
    COUNTERLOADEN = 1'b1;
    COUNTERLOADVAL = v;
    cyc();
    COUNTERLOADEN = 1'b0;
  endtask

  task automatic read(int l, logic [TW-1:0] exp);
    LANESEL = 2'(l);
    COUNTERREADEN = 1'b1;
    rdq.push_back(exp);
    cyc();
    COUNTERREADEN = 1'b0;
  endtask

  task automatic os_count(output int c);
    c = 0;
    repeat (6) begin
      @(negedge SYSCLK);
      if (OSERDESRST == 4'hF) c++;
    end
  endtask

  // monitor: every read pulse pops one expected value
  always @(negedge SYSCLK) begin
    if (!RST && READVALID) begin
      if (rdq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL read_unexpected: got %0h want none", COUNTERREADVAL);
      end else begin
        logic [TW-1:0] e;
        e = rdq.pop_front();
        check("readval", COUNTERREADVAL, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (2) @(posedge SYSCLK);
    @(negedge SYSCLK);
    check("rst_finetap", FINETAP, 0);
    check("rst_coarsetap", COARSETAP, 0);
    check("rst_flags", {FINEOVERFLOW, COARSEOVERFLOW}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_readvalid", READVALID, 0);
    check("rst_readval", COUNTERREADVAL, 0);
    check("rst_oserdes", OSERDESRST, 4'hF);
    RST = 1'b0;
    os_count(c);
    check("rst_os_len", c, 4);
    check("rst_os_end", OSERDESRST, 0);

    for (int i = 0; i < 64; i++) begin
      fine(2, 1'b1);
      settle();
      if (i == 62) begin
        check("fine_63", ftap(2), 63);
        check("fine_no_ovf", FINEOVERFLOW, 0);
      end
    end
    check("fine_wrap", FINETAP, 0);
    check("fine_ovf", FINEOVERFLOW, 4'b0100);
    fine(0, 1'b0);
    settle();
    check("fine_dec_wrap", ftap(0), 63);
    check("fine_dec_ovf", FINEOVERFLOW, 4'b0101);

    load(1, 9'h1CA);
    settle();
    coarse(1, 1'b1);
    @(negedge SYSCLK);
    check("busy_c1", BUSY, 1);
    @(negedge SYSCLK);
    check("busy_c2", BUSY, 1);
    @(negedge SYSCLK);
    check("busy_c3", BUSY, 0);
    check("coarse_sat", ctap(1), 7);
    check("coarse_fine", ftap(1), 10);
    check("coarse_ovf", COARSEOVERFLOW, 4'b0010);
    coarse(3, 1'b0);
    settle();
    check("coarse_dec_sat", ctap(3), 0);
    check("coarse_dec_ovf", COARSEOVERFLOW, 4'b1010);

    LANESEL = 2'd0;
    COUNTERLOADEN = 1'b1;
    COUNTERLOADVAL = 9'h085;
    COARSEENABLE = 1'b1;
    COARSEINC = 1'b1;
    FINEENABLE = 1'b1;
    FINEINC = 1'b1;
    cyc();
    COUNTERLOADEN = 1'b0;
    COARSEENABLE = 1'b0;
    FINEENABLE = 1'b0;
    fine(0, 1'b1);
    cyc();
    check("prio_fine", ftap(0), 5);
    check("prio_coarse", ctap(0), 2);
    check("prio_fovf", FINEOVERFLOW, 4'b0100);
    check("prio_busy_end", BUSY, 0);

    LANESEL = 2'd3;
    COUNTERLOADEN = 1'b1;
    COUNTERLOADVAL = 9'h0A5;
    COUNTERREADEN = 1'b1;
    rdq.push_back(9'h000);
    cyc();
    COUNTERLOADEN = 1'b0;
    COUNTERREADEN = 1'b0;
    settle();
    read(3, 9'h0A5);
    cyc();
    check("read_pulse", READVALID, 0);
    check("read_hold", COUNTERREADVAL, 9'h0A5);
    check("load_clr_ovf", COARSEOVERFLOW, 4'b0010);
    read(2, 9'h000);
    read(1, 9'h1CA);
    cyc();

    @(negedge SYSCLK);
    DIVIDERST = 1'b1;
    c = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge SYSCLK);
      if (OSERDESRST == 4'hF) c++;
      if (i == 6) check("div_os_end", OSERDESRST, 0);
      DIVIDERST = (i == 1);
    end
    check("div_os_len", c, 6);

    load(2, 9'h1FF);
    check("abort_loaded", ftap(2), 63);
    check("abort_busy", BUSY, 1);
    #3;
    RST = 1'b1;
    #1;
    check("abort_finetap", FINETAP, 0);
    check("abort_coarsetap", COARSETAP, 0);
    check("abort_flags", {FINEOVERFLOW, COARSEOVERFLOW}, 0);
    check("abort_busy0", BUSY, 0);
    check("abort_readval", COUNTERREADVAL, 0);
    check("abort_os", OSERDESRST, 4'hF);
    @(negedge SYSCLK);
    RST = 1'b0;
    os_count(c);
    check("abort_os_len", c, 4);
    check("abort_os_end", OSERDESRST, 0);
    read(2, 9'h000);
    cyc();
    cyc();
    check("queue_drained", rdq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phaser_tap_ctrl.md
PHASER_TAP_CTRL -- requirements
Module: phaser_tap_ctrl

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent delay lanes (1..8).
REQ-002 SHALL have parameter FINE_W, default 6, fine tap width; fine taps 0..2^FINE_W-1.
REQ-003 SHALL have parameter COARSE_W, default 3, coarse tap width.
REQ-004 SHALL have parameter COARSE_MAX, default 7, highest legal coarse tap (<= 2^COARSE_W-1).
REQ-005 SHALL have parameter SETTLE, default 2, busy cycles after any tap change (1..15).
REQ-006 SHALL have parameter EN_OSERDES_RST, default 1, 1 enables OSERDESRST generation.
REQ-007 SHALL have parameter RST_PULSE, default 4, OSERDESRST pulse length in cycles (1..15).
REQ-008 SHALL have port SYSCLK  in  1  sole clock, all state on rising edge.
REQ-009 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port LANESEL  in  max(1,clog2(LANES))  target lane for step/load/read.
REQ-011 SHALL have ports FINEENABLE, FINEINC, COARSEENABLE, COARSEINC  in  1 each  step request and direction (1=inc).
REQ-012 SHALL have port COUNTERLOADEN  in  1  load request; COUNTERLOADVAL  in  FINE_W+COARSE_W  {coarse,fine}.
REQ-013 SHALL have port COUNTERREADEN  in  1  read request; COUNTERREADVAL  out  FINE_W+COARSE_W  {coarse,fine}.
REQ-014 SHALL have port DIVIDERST  in  1  divider/serializer resync request.
REQ-015 SHALL have outputs READVALID 1, BUSY 1, FINEOVERFLOW LANES, COARSEOVERFLOW LANES, OSERDESRST LANES.
REQ-016 SHALL have outputs FINETAP LANES*FINE_W and COARSETAP LANES*COARSE_W, lane i at slice i.

Function
REQ-017 SHALL run FSM states IDLE, SETTLE, RSTPULSE-independent (OSERDESRST counter runs in parallel with FSM).
REQ-018 In IDLE, SHALL accept one request per cycle, priority COUNTERLOADEN > COARSEENABLE > FINEENABLE; lower requests that cycle are dropped.
REQ-019 Accepted request SHALL update the selected lane's tap on the next edge, then enter SETTLE with BUSY=1 for exactly SETTLE cycles, then return to IDLE.
REQ-020 Step/load requests while BUSY=1 SHALL be ignored with no state change.
REQ-021 Fine inc at 2^FINE_W-1 SHALL wrap to 0 and set sticky FINEOVERFLOW[lane]; fine dec at 0 SHALL wrap to max and set the same flag.
REQ-022 Coarse inc at COARSE_MAX and coarse dec at 0 SHALL saturate (tap unchanged), set sticky COARSEOVERFLOW[lane], and still enter SETTLE.
REQ-023 Load SHALL write fine and coarse taps of the lane, clamping coarse to COARSE_MAX, and clear both overflow flags of that lane.
REQ-024 Out-of-range LANESEL (>= LANES) SHALL be ignored for step/load; read returns 0 with READVALID asserted.
REQ-025 COUNTERREADEN SHALL be accepted in any state; COUNTERREADVAL registered one cycle later with READVALID a one-cycle pulse; value is pre-update if a load/step hits the same lane in the same cycle.
REQ-026 COUNTERREADVAL SHALL hold its last value when READVALID=0.
REQ-027 With EN_OSERDES_RST=1, DIVIDERST sampled high SHALL assert all OSERDESRST bits from the next cycle for RST_PULSE cycles; DIVIDERST during a pulse restarts the count.
REQ-028 With EN_OSERDES_RST=0, OSERDESRST SHALL be constant 0.
REQ-029 Tap outputs SHALL be registered, changing only on the edge that applies a step/load.

Reset
REQ-030 RST high SHALL immediately force: taps 0, overflow flags 0, FSM IDLE, BUSY 0, READVALID 0, COUNTERREADVAL 0.
REQ-031 With EN_OSERDES_RST=1, OSERDESRST SHALL be all-ones during RST and for RST_PULSE cycles after RST deassertion; otherwise 0.
REQ-032 RST asserted mid-SETTLE or mid-pulse SHALL abort and apply REQ-030/031 values without glitch to other state.

Verification
REQ-033 Defaults; lane 2: 64 FINEENABLE+FINEINC steps spaced 3 cycles -> FINETAP[2] wraps 63->0, FINEOVERFLOW[2]=1, other lanes 0.
REQ-034 Load lane 1 with {3'd7,6'd10}, then COARSEINC -> COARSETAP[1]=7 unchanged, COARSEOVERFLOW[1]=1, BUSY high 2 cycles.
REQ-035 Same-cycle LOADEN+COARSEENABLE+FINEENABLE on lane 0 -> only load applied; step issued while BUSY=1 -> no change.
REQ-036 Load lane 3 with 9'h0A5 and COUNTERREADEN lane 3 same cycle -> READVALID next cycle with 9'h000; re-read -> 9'h0A5.
REQ-037 DIVIDERST pulse, repeated 2 cycles later -> OSERDESRST=4'hF for 6 consecutive cycles total.
REQ-038 RST asserted mid-SETTLE after taps loaded -> all outputs to reset values same cycle; OSERDESRST high 4 cycles after release.
